// File: rtl/fpu_operand_unpack.sv
// Packed IEEE-754 operand unpacker: sign, unbiased exponent, explicit-hidden-bit significand
// and one-hot class. Subnormals are normalized 8 bits per cycle before being presented.
module fpu_operand_unpack #(
  parameter int unsigned FLEN = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [FLEN-1:0]                fp_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [FLEN-1:0]                fp_o,
  output logic                           sign_o,
  output logic signed [((FLEN == 64) ? 11 : 8)+2:0] exp_o,
  output logic [2*((FLEN == 64) ? 52 : 23)+1:0]     sig_o,
  output logic [5:0]                     class_o
);

  localparam int unsigned NEXP     = (FLEN == 64) ? 11 : 8;
  localparam int unsigned NSIG     = (FLEN == 64) ? 52 : 23;
  localparam int unsigned NFULLSIG = 2 * NSIG + 1;
  localparam int unsigned SIGW     = NFULLSIG + 1;
  localparam int unsigned EXPW     = NEXP + 3;
  localparam int unsigned HID      = 2 * NSIG;
  localparam int          Bias     = (2 ** (NEXP - 1)) - 1;
  localparam int          Emax     = Bias;
  localparam int          Emin     = 1 - Bias;

  localparam logic [5:0] ClsZero   = 6'b000001;
  localparam logic [5:0] ClsSub    = 6'b000010;
  localparam logic [5:0] ClsNormal = 6'b000100;
  localparam logic [5:0] ClsInf    = 6'b001000;
  localparam logic [5:0] ClsSnan   = 6'b010000;
  localparam logic [5:0] ClsQnan   = 6'b100000;

  typedef enum logic [1:0] {StIdle, StNorm, StOut} state_e;

  state_e                 state_q;
  // Working copy of a subnormal while it is being normalized.
  logic [FLEN-1:0]        fp_w_q;
  logic                   sign_w_q;
  logic [SIGW-1:0]        sig_w_q;
  logic signed [EXPW-1:0] exp_w_q;
  // Presented outputs; only loaded on entry to StOut.
  logic [FLEN-1:0]        fp_q;
  logic                   sign_q;
  logic [SIGW-1:0]        sig_q;
  logic signed [EXPW-1:0] exp_q;
  logic [5:0]             class_q;

  logic [NEXP-1:0]        in_exp;
  logic [NSIG-1:0]        in_frac;
  logic [5:0]             in_class;
  logic signed [EXPW-1:0] in_exp_val;
  logic [SIGW-1:0]        in_sig;

  logic [7:0]             norm_win;
  logic [3:0]             norm_shift;
  logic [SIGW-1:0]        norm_sig;
  logic signed [EXPW-1:0] norm_exp;

  // Leading-zero count of a non-zero byte.
  function automatic logic [2:0] lzc8(input logic [7:0] w);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w[i]) n = 3'(7 - i);
    end
    return n;
  endfunction

  // Classify the incoming operand and form its final (or initial subnormal) values.
  always_comb begin
    in_exp     = fp_i[FLEN-2 -: NEXP];
    in_frac    = fp_i[NSIG-1:0];
    in_class   = ClsNormal;
    in_exp_val = $signed(EXPW'(in_exp)) - $signed(EXPW'(Bias));
    in_sig     = {2'b01, in_frac, {NSIG{1'b0}}};
    if (in_exp == '0) begin
      if (in_frac == '0) begin
        in_class   = ClsZero;
        in_exp_val = EXPW'(Emin - 1);
        in_sig     = '0;
      end else begin
        in_class   = ClsSub;
        in_exp_val = EXPW'(Emin);
        in_sig     = {2'b00, in_frac, {NSIG{1'b0}}};
      end
    end else if (in_exp == '1) begin
      in_exp_val = EXPW'(Emax + 1);
      if (in_frac == '0)         in_class = ClsInf;
      else if (in_frac[NSIG-1])  in_class = ClsQnan;
      else                       in_class = ClsSnan;
    end
  end

  // One normalization step: a full byte shift when the top window is empty, else finish.
  always_comb begin
    norm_win   = sig_w_q[HID -: 8];
    norm_shift = (norm_win == 8'd0) ? 4'd8 : {1'b0, lzc8(norm_win)};
    norm_sig   = sig_w_q << norm_shift;
    norm_exp   = exp_w_q - $signed(EXPW'(norm_shift));
  end

  // Control FSM together with the working and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      fp_w_q   <= '0;
      sign_w_q <= 1'b0;
      sig_w_q  <= '0;
      exp_w_q  <= '0;
      fp_q     <= '0;
      sign_q   <= 1'b0;
      sig_q    <= '0;
      exp_q    <= '0;
      class_q  <= '0;
    end else if (flush_i) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (valid_i) begin
            if (in_class == ClsSub) begin
              fp_w_q   <= fp_i;
              sign_w_q <= fp_i[FLEN-1];
              sig_w_q  <= in_sig;
              exp_w_q  <= in_exp_val;
              state_q  <= StNorm;
            end else begin
              fp_q    <= fp_i;
              sign_q  <= fp_i[FLEN-1];
              sig_q   <= in_sig;
              exp_q   <= in_exp_val;
              class_q <= in_class;
              state_q <= StOut;
            end
          end
        end
        StNorm: begin
          if (norm_win == 8'd0) begin
            sig_w_q <= norm_sig;
            exp_w_q <= norm_exp;
          end else begin
            fp_q    <= fp_w_q;
            sign_q  <= sign_w_q;
            sig_q   <= norm_sig;
            exp_q   <= norm_exp;
            class_q <= ClsSub;
            state_q <= StOut;
          end
        end
        StOut: begin
          if (ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o = (state_q == StIdle);
  assign valid_o = (state_q == StOut);
  assign fp_o    = fp_q;
  assign sign_o  = sign_q;
  assign exp_o   = exp_q;
  assign sig_o   = sig_q;
  assign class_o = class_q;

endmodule
